// File: rtl/fetch_unit.sv
// Instruction fetch stage: credit-limited imem requests, an in-order response FIFO toward decode,
// and a redirect flush that discards responses to requests issued before the redirect.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst_data,
  output logic [31:0] inst_pc
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int SW = CW + 2;
  localparam logic [CW-1:0] CNT_ZERO = CW'(0);
  localparam logic [AW-1:0] PTR_ZERO = AW'(0);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);
  localparam logic [SW-1:0] LIMIT    = SW'(DEPTH);

  logic [31:0]   fetch_pc_r;
  logic [31:0]   resp_pc_r;
  logic [CW-1:0] inflight_r;
  logic [CW-1:0] drop_r;
  logic [CW-1:0] count_r;
  logic [AW-1:0] rd_ptr_r;
  logic [AW-1:0] wr_ptr_r;
  logic [31:0]   fifo_data_r [DEPTH];
  logic [31:0]   fifo_pc_r   [DEPTH];

  logic [SW-1:0] credit_sum_s;
  logic          req_fire_s;
  logic          resp_drop_s;
  logic          resp_live_s;
  logic          push_s;
  logic          pop_s;

  // Credit check and handshake strobes, derived only from registered state and inputs.
  always_comb begin
    credit_sum_s = SW'(inflight_r) + SW'(drop_r) + SW'(count_r);
    // Gated by rst_n so the request stays low while reset is held.
    imem_req_valid = rst_n & (credit_sum_s < LIMIT);
    req_fire_s     = imem_req_valid & imem_req_ready;
    resp_drop_s    = imem_resp_valid & (drop_r != CNT_ZERO);
    // Orphan responses (nothing outstanding) are ignored.
    resp_live_s    = imem_resp_valid & (drop_r == CNT_ZERO) & (inflight_r != CNT_ZERO);
    push_s         = resp_live_s & ~redirect_valid;
    pop_s          = inst_ready & (count_r != CNT_ZERO) & ~redirect_valid;
  end

  // Fetch PC, response PC, credit counters and FIFO storage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc_r <= RESET_PC;
      resp_pc_r  <= RESET_PC;
      inflight_r <= CNT_ZERO;
      drop_r     <= CNT_ZERO;
      count_r    <= CNT_ZERO;
      rd_ptr_r   <= PTR_ZERO;
      wr_ptr_r   <= PTR_ZERO;
      for (int i = 0; i < DEPTH; i++) begin
        fifo_data_r[i] <= 32'h0000_0000;
        fifo_pc_r[i]   <= 32'h0000_0000;
      end
    end else if (redirect_valid) begin
      // Everything still outstanding, including a request accepted right now, becomes stale.
      fetch_pc_r <= {redirect_pc[31:2], 2'b00};
      resp_pc_r  <= {redirect_pc[31:2], 2'b00};
      inflight_r <= CNT_ZERO;
      count_r    <= CNT_ZERO;
      rd_ptr_r   <= PTR_ZERO;
      wr_ptr_r   <= PTR_ZERO;
      drop_r     <= drop_r + inflight_r + CW'(req_fire_s) - CW'(resp_drop_s | resp_live_s);
    end else begin
      if (req_fire_s) begin
        fetch_pc_r <= fetch_pc_r + 32'd4;
      end
      if (push_s) begin
        fifo_data_r[wr_ptr_r] <= imem_resp_data;
        fifo_pc_r[wr_ptr_r]   <= resp_pc_r;
        wr_ptr_r              <= wr_ptr_r + PTR_ONE;
        resp_pc_r             <= resp_pc_r + 32'd4;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
      inflight_r <= inflight_r + CW'(req_fire_s) - CW'(resp_live_s);
      drop_r     <= drop_r - CW'(resp_drop_s);
      count_r    <= count_r + CW'(push_s) - CW'(pop_s);
    end
  end

  assign imem_req_addr = fetch_pc_r;
  assign inst_valid    = (count_r != CNT_ZERO);
  assign inst_data     = fifo_data_r[rd_ptr_r];
  assign inst_pc       = fifo_pc_r[rd_ptr_r];

  fetch_unit_checker #(.CW(CW), .DEPTH(DEPTH)) u_checker (
    .clk        (clk),
    .rst_n      (rst_n),
    .resp_valid (imem_resp_valid),
    .inflight   (inflight_r),
    .drop       (drop_r),
    .count      (count_r)
  );
endmodule

// Simulation-only protocol and credit invariants for fetch_unit.
module fetch_unit_checker #(
  parameter int CW    = 3,
  parameter int DEPTH = 4
) (
  input logic          clk,
  input logic          rst_n,
  input logic          resp_valid,
  input logic [CW-1:0] inflight,
  input logic [CW-1:0] drop,
  input logic [CW-1:0] count
);
  localparam int SW = CW + 2;

  logic [SW-1:0] total_s;
  assign total_s = SW'(inflight) + SW'(drop) + SW'(count);

  a_no_orphan_resp: assert property (@(posedge clk) disable iff (!rst_n)
    resp_valid |-> (inflight != CW'(0) || drop != CW'(0)));

  a_credit_bound: assert property (@(posedge clk) disable iff (!rst_n)
    total_s <= SW'(DEPTH));
endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
Instruction fetch stage directly upstream of decode, which feeds the fetched 32-bit instruction word to immediate_decoder via the `in` input.
- Holds the fetch PC and issues word requests to instruction memory.
- Buffers in-order responses in a small FIFO and presents {pc, instruction} to decode over a valid/ready handshake.
- Handles control-flow redirects by flushing the FIFO and discarding stale in-flight responses.

Parameters:
RESET_PC, 32'h0000_0000, first fetch address after reset; bits [1:0] must be 0.
DEPTH, 4, FIFO entries; also the maximum of (in-flight requests + buffered words); power of two, minimum 2.

Ports:
clk  input  1  clock; all state updates on rising edge.
rst_n  input  1  asynchronous active-low reset.
imem_req_valid  output  1  fetch request valid.
imem_req_ready  input  1  memory accepts the request this cycle.
imem_req_addr  output  32  word address of the request; bits [1:0] always 0.
imem_resp_valid  input  1  response word valid; responses return in request order, at least 1 cycle after acceptance.
imem_resp_data  input  32  response instruction word.
redirect_valid  input  1  control-flow change from execute.
redirect_pc  input  32  new fetch PC; bits [1:0] are ignored and forced to 0.
inst_valid  output  1  FIFO head valid toward decode.
inst_ready  input  1  decode consumes the head this cycle.
inst_data  output  32  instruction word at the FIFO head.
inst_pc  output  32  PC of the instruction at the FIFO head.

Behaviour:
- Reset (asynchronous, rst_n=0):
  - fetch_pc=RESET_PC; FIFO empty; inflight=0; drop=0.
  - Outputs: imem_req_valid=0, imem_req_addr=RESET_PC, inst_valid=0, inst_data=0, inst_pc=0.
- Request issue:
  - imem_req_valid = (inflight + drop + count < DEPTH), using registered values only. No combinational path from inst_ready or imem_resp_valid.
  - imem_req_addr = fetch_pc.
  - On a handshake (valid & ready): fetch_pc += 4, wrapping modulo 2^32, and inflight++.
  - While valid=1 and ready=0, the address is held stable, unless a redirect occurs.
- Response:
  - When imem_resp_valid=1 and drop>0: drop--; the word is discarded.
  - Otherwise the word is pushed with PC = resp_pc, then resp_pc += 4 and inflight--.
  - resp_pc tracks the PC of the oldest live in-flight request.
  - The credit rule guarantees the FIFO never overflows.
  - A response arriving with inflight+drop=0 is a protocol error; assert it in simulation and ignore it in RTL.
- Decode handshake:
  - inst_valid = (count != 0).
  - The FIFO head is registered, so a response in cycle N is visible at inst_valid in cycle N+1.
  - Push and pop in the same cycle are both honoured; count is unchanged.
- Redirect (redirect_valid=1) has highest priority. Next-state values:
  - FIFO count=0, so inst_valid=0 next cycle. Any pop this cycle is ignored, and a response arriving this cycle is not pushed.
  - drop_next = drop + inflight + (req handshake this cycle) − (resp arriving this cycle).
  - inflight_next = 0.
  - fetch_pc_next = resp_pc_next = {redirect_pc[31:2], 2'b00}.
  - A request accepted in the same cycle as a redirect is stale and counted in drop.
  - The next request, no earlier than the following cycle, uses the redirect address.
  - Back-to-back redirects: the last one wins; drop accumulates.
- Counter widths: inflight, drop and count are $clog2(DEPTH)+1 bits; inflight+drop+count ≤ DEPTH always.
- rst_n asserted mid-transaction: all state clears immediately. Memory is also reset, so no late responses arrive.

Test Plan:
1. Reset release with RESET_PC=32'h100 and memory always ready with 1-cycle latency, inst_ready=1 → requests 0x100, 0x104, 0x108…; the first inst_valid appears 2 cycles after the first request handshake with inst_pc=0x100; sustained throughput of 1 instruction per cycle at DEPTH=4.
2. inst_ready=0 with memory ready → exactly 4 requests issued (0x100–0x10C), then imem_req_valid=0; one inst_ready pulse pops 0x100, and one new request to 0x110 follows.
3. Redirect to 0x2002 with 2 requests in flight and 1 word buffered → next inst_valid=0; both stale responses are dropped; the next request address is 0x2000; the first delivered inst_pc is 0x2000.
4. Same cycle: redirect to 0x400, request handshake, response arrival, and decode pop → drop = prior inflight+1−1; that response is not delivered; the first new inst_pc is 0x400.
5. imem_req_ready held 0 for 5 cycles → imem_req_valid=1 with address held at 0xFFFF_FFFC; after acceptance the next address is 0x0000_0000 (wrap).
6. rst_n asserted with 3 words buffered and 1 in flight → all outputs return to reset values asynchronously, before the next clock edge.
